// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    typedef enum logic {
        FETCH_ST = 1'b0,
        HALT_ST  = 1'b1
    } state_t;

    // All-zero word marks the end of the program.
    localparam logic [31:0] END_INSTR  = 32'h0;
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Show-ahead FIFO: head entry is visible on rdata whenever count is nonzero.
module fetch_fifo #(
    parameter int unsigned WIDTH = 44,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads, queues returns for decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned         PC_WIDTH    = 12,
    parameter int unsigned         INSTR_WIDTH = 32,
    parameter int unsigned         QUEUE_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   flush,
    input  logic [PC_WIDTH-1:0]    flush_pc,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   done
);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned OW = CW + 1;
    localparam int unsigned EW = PC_WIDTH + INSTR_WIDTH;

    state_t              state;
    state_t              state_nx;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_nx;
    logic [PC_WIDTH-1:0] addr_q;
    logic [PC_WIDTH-1:0] addr_nx;
    logic [PC_WIDTH-1:0] ret_pc;
    logic [PC_WIDTH-1:0] redirect;
    logic                req_q;
    logic                req_nx;
    logic                inflight;
    logic                end_word;
    logic                halt_hit;
    logic                push;
    logic                pop;
    logic [CW-1:0]       count;
    logic [OW-1:0]       occ_nx;
    logic [EW-1:0]       head;

    assign end_word = (imem_rdata == INSTR_WIDTH'(END_INSTR));
    assign halt_hit = !flush && inflight && (state == FETCH_ST) && end_word;
    assign push     = !flush && inflight && (state == FETCH_ST) && !end_word;
    assign pop      = !flush && valid_out && ready_in;
    assign redirect = flush_pc & ~PC_WIDTH'(WORD_BYTES - 1);

    // A pending request is withdrawn when flushing or when the end word arrives.
    assign imem_req  = req_q && !flush && !halt_hit;
    assign imem_addr = addr_q;

    assign valid_out = (count != '0);
    assign done      = (state == HALT_ST) && (count == '0) && !inflight;
    assign pc_out    = head[EW-1:INSTR_WIDTH];
    assign instr_out = head[INSTR_WIDTH-1:0];

    // Occupancy after this edge, counting the word requested this cycle.
    assign occ_nx = OW'(count) + OW'(push) + OW'(imem_req) - OW'(pop);

    always_comb begin
        state_nx = state;
        req_nx   = 1'b0;
        addr_nx  = addr_q;
        pc_nx    = pc;
        if (flush) begin
            state_nx = FETCH_ST;
            req_nx   = 1'b1;
            addr_nx  = redirect;
            pc_nx    = redirect + PC_WIDTH'(WORD_BYTES);
        end else begin
            if (halt_hit) state_nx = HALT_ST;
            if ((state_nx == FETCH_ST) && (occ_nx < OW'(QUEUE_DEPTH))) begin
                req_nx  = 1'b1;
                addr_nx = pc;
                pc_nx   = pc + PC_WIDTH'(WORD_BYTES);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH_ST;
            pc       <= RESET_PC;
            addr_q   <= RESET_PC;
            req_q    <= 1'b0;
            inflight <= 1'b0;
            ret_pc   <= '0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            addr_q   <= addr_nx;
            req_q    <= req_nx;
            inflight <= imem_req;
            ret_pc   <= imem_addr;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .wdata ({ret_pc, imem_rdata}),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboarded decode stream plus cycle-exact request checks.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        imem_req, flush, valid_out, ready_in, done;
    logic [11:0] imem_addr, flush_pc, pc_out;
    logic [31:0] imem_rdata = '0, instr_out;

    logic        imem_req1, flush1, valid_out1, ready1, done1;
    logic [11:0] imem_addr1, flush_pc1, pc_out1;
    logic [31:0] imem_rdata1 = '0, instr_out1;

    logic [31:0] mem0 [1024];
    logic [43:0] exp0 [$];
    logic [43:0] exp1 [$];
    int          total = 0;
    int          bad = 0;

    fetch_unit u0 (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .flush(flush), .flush_pc(flush_pc),
        .valid_out(valid_out), .ready_in(ready_in), .pc_out(pc_out),
        .instr_out(instr_out), .done(done)
    );

    fetch_unit #(.RESET_PC(12'hFF8)) u1 (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req1), .imem_addr(imem_addr1),
        .imem_rdata(imem_rdata1), .flush(flush1), .flush_pc(flush_pc1),
        .valid_out(valid_out1), .ready_in(ready1), .pc_out(pc_out1),
        .instr_out(instr_out1), .done(done1)
    );

    function automatic logic [31:0] pat1(input logic [11:0] a);
        return 32'hC000_0000 | {22'd0, a[11:2]};
    endfunction

    // Synchronous instruction memories: data one cycle after the request.
    always @(posedge clk) if (imem_req)  imem_rdata  <= mem0[imem_addr[11:2]];
    always @(posedge clk) if (imem_req1) imem_rdata1 <= pat1(imem_addr1);

    task automatic fill_mem(input logic [31:0] base);
        for (int i = 0; i < 1024; i++) mem0[i] = base | 32'(i);
    endtask

    task automatic apply_reset();
        ready_in = 1'b0; ready1 = 1'b0; flush = 1'b0; flush_pc = '0;
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        fill_mem(32'hA500_0000);
        ready_in = 1'b0; ready1 = 1'b0; flush = 1'b0; flush_pc = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({imem_req, valid_out, done} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl got req/valid/done=%b want 000", {imem_req, valid_out, done});
        end
        total++;
        if (imem_addr !== 12'h000) begin
            bad++; $display("FAIL reset_addr got %h want 000", imem_addr);
        end
        total++;
        if ({pc_out, instr_out} !== 44'd0) begin
            bad++; $display("FAIL reset_head got pc=%h instr=%h want 0/0", pc_out, instr_out);
        end
        total++;
        if (imem_addr1 !== 12'hFF8) begin
            bad++; $display("FAIL reset_addr_ff8 got %h want ff8", imem_addr1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_program_end();
        logic [43:0] e;
        logic        ereq, evalid, edone;
        int          pops = 0;
        fill_mem(32'hA500_0000);
        mem0[0] = 32'h0050_0093; mem0[1] = 32'h00A0_0113; mem0[2] = 32'h0;
        exp0.delete();
        exp0.push_back({12'h000, 32'h0050_0093});
        exp0.push_back({12'h004, 32'h00A0_0113});
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1 ready_in = 1'b1;
            @(negedge clk);
            ereq = (k < 3); evalid = (k == 2 || k == 3); edone = (k >= 4);
            total++;
            if ({imem_req, valid_out, done} !== {ereq, evalid, edone}) begin
                bad++; $display("FAIL prog_ctrl c%0d got req/valid/done=%b want %b", k, {imem_req, valid_out, done}, {ereq, evalid, edone});
            end
            if (ereq) begin
                total++;
                if (imem_addr !== 12'(4 * k)) begin
                    bad++; $display("FAIL prog_addr c%0d got %h want %h", k, imem_addr, 12'(4 * k));
                end
            end
            if (valid_out && ready_in) begin
                total++; pops++;
                e = (exp0.size() != 0) ? exp0.pop_front() : '1;
                if ({pc_out, instr_out} !== e) begin
                    bad++; $display("FAIL prog_sb got %h_%h want %h", pc_out, instr_out, e);
                end
            end
        end
        total++;
        if (pops != 2 || exp0.size() != 0) begin
            bad++; $display("FAIL prog_count got pops=%0d left=%0d want 2/0", pops, exp0.size());
        end
    endtask

    task automatic test_backpressure();
        logic [43:0] e;
        int          pops = 0;
        fill_mem(32'hA500_0000);
        exp0.delete();
        for (int i = 0; i < 12; i++) exp0.push_back({12'(4 * i), 32'hA500_0000 | 32'(i)});
        apply_reset();
        for (int k = 0; k < 22; k++) begin
            @(posedge clk); #1 ready_in = (k >= 10);
            @(negedge clk);
            if (k < 10) begin
                total++;
                if (imem_req !== 1'(k < 4)) begin
                    bad++; $display("FAIL bp_req c%0d got %b want %b", k, imem_req, 1'(k < 4));
                end
            end
            if (k < 4 || k == 11) begin
                total++;
                if (imem_req !== 1'b1 || imem_addr !== 12'(4 * k) - ((k == 11) ? 12'h01C : 12'h000)) begin
                    bad++; $display("FAIL bp_addr c%0d got req=%b addr=%h", k, imem_req, imem_addr);
                end
            end
            if (k >= 2 && k < 10) begin
                total++;
                if ({valid_out, pc_out, instr_out} !== {1'b1, 12'h000, 32'hA500_0000}) begin
                    bad++; $display("FAIL bp_hold c%0d got v=%b pc=%h instr=%h want 1/000/a5000000", k, valid_out, pc_out, instr_out);
                end
            end
            if (valid_out && ready_in) begin
                total++; pops++;
                e = (exp0.size() != 0) ? exp0.pop_front() : '1;
                if ({pc_out, instr_out} !== e) begin
                    bad++; $display("FAIL bp_sb got %h_%h want %h", pc_out, instr_out, e);
                end
            end
        end
        total++;
        if (pops != 12 || exp0.size() != 0) begin
            bad++; $display("FAIL bp_count got pops=%0d left=%0d want 12/0", pops, exp0.size());
        end
    endtask

    task automatic test_flush();
        logic [43:0] e;
        int          pops = 0;
        fill_mem(32'hA500_0000);
        exp0.delete();
        for (int i = 0; i < 6; i++) exp0.push_back({12'h100 + 12'(4 * i), 32'hA500_0040 | 32'(i)});
        apply_reset();
        for (int k = 0; k < 13; k++) begin
            @(posedge clk); #1;
            flush = (k == 4); flush_pc = 12'h103; ready_in = (k >= 7);
            @(negedge clk);
            if (k == 4) begin
                total++;
                if ({imem_req, valid_out, pc_out} !== {1'b0, 1'b1, 12'h000}) begin
                    bad++; $display("FAIL flush_cycle got req=%b v=%b pc=%h want 0/1/000", imem_req, valid_out, pc_out);
                end
            end
            if (k == 5 || k == 6) begin
                total++;
                if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 12'h100 + 12'(4 * (k - 5))}) begin
                    bad++; $display("FAIL flush_redirect c%0d got v=%b req=%b addr=%h", k, valid_out, imem_req, imem_addr);
                end
            end
            if (k == 7) begin
                total++;
                if ({valid_out, pc_out} !== {1'b1, 12'h100}) begin
                    bad++; $display("FAIL flush_first got v=%b pc=%h want 1/100", valid_out, pc_out);
                end
            end
            if (valid_out && ready_in) begin
                total++; pops++;
                e = (exp0.size() != 0) ? exp0.pop_front() : '1;
                if ({pc_out, instr_out} !== e) begin
                    bad++; $display("FAIL flush_sb got %h_%h want %h", pc_out, instr_out, e);
                end
            end
        end
        flush = 1'b0;
        total++;
        if (pops != 6 || exp0.size() != 0) begin
            bad++; $display("FAIL flush_count got pops=%0d left=%0d want 6/0", pops, exp0.size());
        end
    endtask

    task automatic test_flush_from_halt();
        logic [43:0] e;
        int          pops = 0;
        fill_mem(32'hA500_0000);
        mem0[1] = 32'h0;
        exp0.delete();
        exp0.push_back({12'h000, 32'hA500_0000});
        for (int i = 0; i < 3; i++) exp0.push_back({12'h020 + 12'(4 * i), 32'hA500_0008 | 32'(i)});
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            flush = (k == 4); flush_pc = 12'h020; ready_in = 1'b1;
            @(negedge clk);
            if (k >= 2 && k <= 4) begin
                total++;
                if ({imem_req, done} !== {1'b0, 1'(k >= 3)}) begin
                    bad++; $display("FAIL halt_state c%0d got req=%b done=%b want 0/%b", k, imem_req, done, 1'(k >= 3));
                end
            end
            if (k == 5) begin
                total++;
                if ({done, imem_req, imem_addr} !== {1'b0, 1'b1, 12'h020}) begin
                    bad++; $display("FAIL halt_restart got done=%b req=%b addr=%h want 0/1/020", done, imem_req, imem_addr);
                end
            end
            if (valid_out && ready_in) begin
                total++; pops++;
                e = (exp0.size() != 0) ? exp0.pop_front() : '1;
                if ({pc_out, instr_out} !== e) begin
                    bad++; $display("FAIL halt_sb got %h_%h want %h", pc_out, instr_out, e);
                end
            end
        end
        flush = 1'b0;
        total++;
        if (pops != 4 || exp0.size() != 0) begin
            bad++; $display("FAIL halt_count got pops=%0d left=%0d want 4/0", pops, exp0.size());
        end
    endtask

    task automatic test_reset_midstream();
        fill_mem(32'hA500_0000);
        apply_reset();
        ready_in = 1'b1;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({imem_req, valid_out, done, imem_addr, pc_out, instr_out} !== 59'd0) begin
            bad++; $display("FAIL mid_reset got req=%b v=%b done=%b addr=%h pc=%h instr=%h want all 0",
                            imem_req, valid_out, done, imem_addr, pc_out, instr_out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1 ready_in = 1'b1;
            @(negedge clk);
            if (k == 0) begin
                total++;
                if ({imem_req, imem_addr, valid_out} !== {1'b1, 12'h000, 1'b0}) begin
                    bad++; $display("FAIL mid_restart got req=%b addr=%h v=%b want 1/000/0", imem_req, imem_addr, valid_out);
                end
            end
            if (k >= 2) begin
                total++;
                if ({valid_out, pc_out, instr_out} !== {1'b1, 12'(4 * (k - 2)), 32'hA500_0000 | 32'(k - 2)}) begin
                    bad++; $display("FAIL mid_stream c%0d got v=%b pc=%h instr=%h", k, valid_out, pc_out, instr_out);
                end
            end
        end
        ready_in = 1'b0;
    endtask

    task automatic test_reset_pc_wrap();
        logic [43:0] e;
        int          pops = 0;
        logic [11:0] p;
        exp1.delete();
        p = 12'hFF8;
        for (int i = 0; i < 7; i++) begin
            exp1.push_back({p, pat1(p)});
            p = p + 12'h004;
        end
        apply_reset();
        for (int k = 0; k < 13; k++) begin
            @(posedge clk); #1 ready1 = (k >= 6);
            @(negedge clk);
            if (k == 5) begin
                total++;
                if ({imem_req1, valid_out1, pc_out1} !== {1'b0, 1'b1, 12'hFF8}) begin
                    bad++; $display("FAIL wrap_stall got req=%b v=%b pc=%h want 0/1/ff8", imem_req1, valid_out1, pc_out1);
                end
            end
            if (valid_out1 && ready1) begin
                total++; pops++;
                e = (exp1.size() != 0) ? exp1.pop_front() : '1;
                if ({pc_out1, instr_out1} !== e) begin
                    bad++; $display("FAIL wrap_sb got %h_%h want %h", pc_out1, instr_out1, e);
                end
            end
        end
        ready1 = 1'b0;
        total++;
        if (pops != 7 || exp1.size() != 0) begin
            bad++; $display("FAIL wrap_count got pops=%0d left=%0d want 7/0", pops, exp1.size());
        end
    endtask

    initial begin
        flush1 = 1'b0; flush_pc1 = '0;
        test_reset();
        test_program_end();
        test_backpressure();
        test_flush();
        test_flush_from_halt();
        test_reset_midstream();
        test_reset_pc_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
